// File: rtl/ysyx_22050550_hazard_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_22050550_hazard_ctrl_pkg
// Shared definitions for the GPR scoreboard / hazard controller:
//   NREG      - number of architectural GPRs (x0..x31)
//   REG_AW    - register address width
//   CNT_W_DEF - default width of each per-register in-flight write counter
// Also holds small helper functions used by the top and its entries.
// ---------------------------------------------------------------------------
package ysyx_22050550_hazard_ctrl_pkg;

    localparam int NREG      = 32;
    localparam int REG_AW    = 5;
    localparam int CNT_W_DEF = 2;

    // True for any architectural register that is actually tracked (x1..x31).
    function automatic logic is_gpr(input logic [REG_AW-1:0] addr);
        return (addr != {REG_AW{1'b0}});
    endfunction

    // True when a register address matches a given entry index.
    function automatic logic addr_hit(input logic [REG_AW-1:0] addr,
                                      input int unsigned       idx);
        return (addr == REG_AW'(idx));
    endfunction

endpackage : ysyx_22050550_hazard_ctrl_pkg

// File: rtl/ysyx_22050550_sb_entry.sv
// ---------------------------------------------------------------------------
// ysyx_22050550_sb_entry
// One scoreboard entry: an up/down counter of in-flight writes to a single
// GPR, with a synchronous clear that overrides everything else.
//   clock   - rising-edge clock
//   reset   - asynchronous active-low reset, clears the count
//   inc     - an instruction writing this register issued this cycle
//   dec     - a write to this register retired this cycle
//   clr     - pipeline flush, clears the count at the next edge
//   count   - current number of in-flight writes (registered)
//   nonzero - count != 0, derived only from the registered count
// inc and dec together leave the count unchanged. A dec on an empty counter
// is dropped, and an inc on a full counter is dropped as a last line of
// defence even though the issue logic never lets that happen.
// ---------------------------------------------------------------------------
module ysyx_22050550_sb_entry
    import ysyx_22050550_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    input  logic             dec,
    input  logic             clr,
    output logic [CNT_W-1:0] count,
    output logic             nonzero
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_nxt_s;

    // Next-count selection: clear first, then a lone inc or a lone dec.
    always_comb begin
        count_nxt_s = count_r;
        if (clr) begin
            count_nxt_s = CNT_ZERO;
        end else if (inc && !dec) begin
            if (count_r != CNT_MAX) begin
                count_nxt_s = count_r + CNT_ONE;
            end else begin
                count_nxt_s = count_r;
            end
        end else if (dec && !inc) begin
            if (count_r != CNT_ZERO) begin
                count_nxt_s = count_r - CNT_ONE;
            end else begin
                count_nxt_s = count_r;
            end
        end else begin
            count_nxt_s = count_r;
        end
    end

    // Count register, wiped immediately by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count_r <= CNT_ZERO;
        end else begin
            count_r <= count_nxt_s;
        end
    end

    assign count   = count_r;
    assign nonzero = (count_r != CNT_ZERO);

endmodule : ysyx_22050550_sb_entry

// File: rtl/ysyx_22050550_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// ysyx_22050550_hazard_ctrl
// GPR scoreboard for in-order issue. Tracks how many writes to each of
// x1..x31 are in flight between issue (IDU) and write-back (WBU), stalls an
// instruction whose sources are still pending, and lets it through when the
// single pending write is retiring this very cycle (WBU forward path).
//   clock, reset          - clock and asynchronous active-low reset
//   io_IDU_valid          - decoded instruction presented for issue
//   io_IDU_raddr1/2       - source registers; io_IDU_ren1/2 source used
//   io_IDU_wen/waddr      - instruction writes GPR io_IDU_waddr
//   io_IDU_ready          - issue accepted when high together with valid
//   io_IDU_pass1/2        - take source n from the WBU forward path
//   io_WBU_valid/waddr    - write retiring this cycle
//   io_flush              - kill all in-flight writes
//   io_busy               - some register still has writes in flight
//   io_stall_cnt          - cycles spent with valid high and ready low
// ---------------------------------------------------------------------------
module ysyx_22050550_hazard_ctrl
    import ysyx_22050550_hazard_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_IDU_valid,
    input  logic [REG_AW-1:0] io_IDU_raddr1,
    input  logic [REG_AW-1:0] io_IDU_raddr2,
    input  logic              io_IDU_ren1,
    input  logic              io_IDU_ren2,
    input  logic              io_IDU_wen,
    input  logic [REG_AW-1:0] io_IDU_waddr,
    output logic              io_IDU_ready,
    output logic              io_IDU_pass1,
    output logic              io_IDU_pass2,
    input  logic              io_WBU_valid,
    input  logic [REG_AW-1:0] io_WBU_waddr,
    input  logic              io_flush,
    output logic              io_busy,
    output logic [31:0]       io_stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    // Per-register counts; x0 is hard-wired to zero so lookups need no guard.
    logic [CNT_W-1:0] cnt_s [NREG];
    logic [NREG-1:0]  nz_s;
    logic [NREG-1:1]  inc_s;
    logic [NREG-1:1]  dec_s;

    logic             issue_s;
    logic             retire_s;
    logic [CNT_W-1:0] src1_cnt_s;
    logic [CNT_W-1:0] src2_cnt_s;
    logic [CNT_W-1:0] dst_cnt_s;
    logic             fwd1_s;
    logic             fwd2_s;
    logic             haz1_s;
    logic             haz2_s;
    logic             full_s;
    logic             ready_s;
    logic             stall_s;
    logic [31:0]      stall_cnt_r;

    assign cnt_s[0] = CNT_ZERO;
    assign nz_s[0]  = 1'b0;

    for (genvar g = 1; g < NREG; g++) begin : g_entry
        ysyx_22050550_sb_entry #(
            .CNT_W   (CNT_W)
        ) u_entry (
            .clock   (clock),
            .reset   (reset),
            .inc     (inc_s[g]),
            .dec     (dec_s[g]),
            .clr     (io_flush),
            .count   (cnt_s[g]),
            .nonzero (nz_s[g])
        );
    end

    // Issue and retire events; only an accepted, writing, non-x0 issue counts.
    always_comb begin
        issue_s  = io_IDU_valid && ready_s && io_IDU_wen && is_gpr(io_IDU_waddr);
        retire_s = io_WBU_valid && is_gpr(io_WBU_waddr);
    end

    // Decode the events onto per-register inc/dec strobes.
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        for (int i = 1; i < NREG; i++) begin
            inc_s[i] = issue_s  && addr_hit(io_IDU_waddr, i);
            dec_s[i] = retire_s && addr_hit(io_WBU_waddr, i);
        end
    end

    // Hazard, forward and ready decisions from the current counts.
    // Forwarding only works when exactly one write is pending: with two
    // pending, the retiring one is not the youngest value.
    // ready deliberately ignores io_IDU_valid so valid never loops back.
    always_comb begin
        src1_cnt_s = cnt_s[io_IDU_raddr1];
        src2_cnt_s = cnt_s[io_IDU_raddr2];
        dst_cnt_s  = cnt_s[io_IDU_waddr];

        fwd1_s = io_WBU_valid && (io_WBU_waddr == io_IDU_raddr1) && (src1_cnt_s == CNT_ONE);
        fwd2_s = io_WBU_valid && (io_WBU_waddr == io_IDU_raddr2) && (src2_cnt_s == CNT_ONE);

        haz1_s = io_IDU_ren1 && is_gpr(io_IDU_raddr1) && (src1_cnt_s != CNT_ZERO) && !fwd1_s;
        haz2_s = io_IDU_ren2 && is_gpr(io_IDU_raddr2) && (src2_cnt_s != CNT_ZERO) && !fwd2_s;

        full_s = io_IDU_wen && (dst_cnt_s == CNT_MAX);

        if (haz1_s || haz2_s || full_s || io_flush) begin
            ready_s = 1'b0;
        end else begin
            ready_s = 1'b1;
        end

        stall_s = io_IDU_valid && !ready_s;
    end

    // Stall cycle counter; wraps freely and is not touched by flush.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_r <= 32'd0;
        end else if (stall_s) begin
            stall_cnt_r <= stall_cnt_r + 32'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign io_IDU_ready = ready_s;
    assign io_IDU_pass1 = io_IDU_valid && io_IDU_ren1 && is_gpr(io_IDU_raddr1) && fwd1_s;
    assign io_IDU_pass2 = io_IDU_valid && io_IDU_ren2 && is_gpr(io_IDU_raddr2) && fwd2_s;
    assign io_busy      = |nz_s;
    assign io_stall_cnt = stall_cnt_r;

endmodule : ysyx_22050550_hazard_ctrl

// File: tb/tb_ysyx_22050550_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ysyx_22050550_hazard_ctrl
// Table-driven bench for the GPR hazard controller (CNT_W = 2). Each table
// row holds the inputs for one cycle and the expected combinational outputs
// for that cycle; expectations are queued when a row is driven and checked
// on the falling edge. A hand-written sequence covers reset mid-stall.
// ---------------------------------------------------------------------------
module tb_ysyx_22050550_hazard_ctrl;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        io_IDU_valid = 1'b0;
    logic [4:0]  io_IDU_raddr1 = 5'd0;
    logic [4:0]  io_IDU_raddr2 = 5'd0;
    logic        io_IDU_ren1 = 1'b0;
    logic        io_IDU_ren2 = 1'b0;
    logic        io_IDU_wen = 1'b0;
    logic [4:0]  io_IDU_waddr = 5'd0;
    logic        io_IDU_ready;
    logic        io_IDU_pass1;
    logic        io_IDU_pass2;
    logic        io_WBU_valid = 1'b0;
    logic [4:0]  io_WBU_waddr = 5'd0;
    logic        io_flush = 1'b0;
    logic        io_busy;
    logic [31:0] io_stall_cnt;

    ysyx_22050550_hazard_ctrl #(.CNT_W(2)) dut (
        .clock         (clock),
        .reset         (reset),
        .io_IDU_valid  (io_IDU_valid),
        .io_IDU_raddr1 (io_IDU_raddr1),
        .io_IDU_raddr2 (io_IDU_raddr2),
        .io_IDU_ren1   (io_IDU_ren1),
        .io_IDU_ren2   (io_IDU_ren2),
        .io_IDU_wen    (io_IDU_wen),
        .io_IDU_waddr  (io_IDU_waddr),
        .io_IDU_ready  (io_IDU_ready),
        .io_IDU_pass1  (io_IDU_pass1),
        .io_IDU_pass2  (io_IDU_pass2),
        .io_WBU_valid  (io_WBU_valid),
        .io_WBU_waddr  (io_WBU_waddr),
        .io_flush      (io_flush),
        .io_busy       (io_busy),
        .io_stall_cnt  (io_stall_cnt)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       v;
        logic [4:0] r1;
        logic       e1;
        logic [4:0] r2;
        logic       e2;
        logic       wen;
        logic [4:0] wa;
        logic       wv;
        logic [4:0] wwa;
        logic       fl;
        logic       x_rdy;
        logic       x_p1;
        logic       x_p2;
        logic       x_busy;
    } vec_t;

    typedef struct {
        int          idx;
        logic        rdy;
        logic        p1;
        logic        p2;
        logic        busy;
        logic [31:0] stall;
    } exp_t;

    vec_t        vecs[$];
    exp_t        sb_q[$];
    int          n_vec  = 0;
    int          n_fail = 0;
    logic [31:0] exp_stall = 32'd0;

    function automatic vec_t mk(logic v, logic [4:0] r1, logic e1, logic [4:0] r2, logic e2,
                                logic wen, logic [4:0] wa, logic wv, logic [4:0] wwa, logic fl,
                                logic x_rdy, logic x_p1, logic x_p2, logic x_busy);
        vec_t t;
        t.v = v;   t.r1 = r1;   t.e1 = e1;   t.r2 = r2;   t.e2 = e2;
        t.wen = wen; t.wa = wa; t.wv = wv;   t.wwa = wwa; t.fl = fl;
        t.x_rdy = x_rdy; t.x_p1 = x_p1; t.x_p2 = x_p2; t.x_busy = x_busy;
        return t;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (vec %0d): got %0h, expected %0h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t t);
        io_IDU_valid  = t.v;
        io_IDU_raddr1 = t.r1;
        io_IDU_ren1   = t.e1;
        io_IDU_raddr2 = t.r2;
        io_IDU_ren2   = t.e2;
        io_IDU_wen    = t.wen;
        io_IDU_waddr  = t.wa;
        io_WBU_valid  = t.wv;
        io_WBU_waddr  = t.wwa;
        io_flush      = t.fl;
    endtask

    // Drive one row after the rising edge, check it on the falling edge.
    task automatic apply(input vec_t t, input int idx);
        exp_t e;
        @(posedge clock);
        #1;
        drive(t);
        e.idx = idx; e.rdy = t.x_rdy; e.p1 = t.x_p1; e.p2 = t.x_p2;
        e.busy = t.x_busy; e.stall = exp_stall;
        sb_q.push_back(e);
        @(negedge clock);
        if (sb_q.size() == 0) begin
            chk("scoreboard_empty", idx, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            chk("ready", e.idx, {31'd0, io_IDU_ready}, {31'd0, e.rdy});
            chk("pass1", e.idx, {31'd0, io_IDU_pass1}, {31'd0, e.p1});
            chk("pass2", e.idx, {31'd0, io_IDU_pass2}, {31'd0, e.p2});
            chk("busy",  e.idx, {31'd0, io_busy},      {31'd0, e.busy});
            chk("stall_cnt", e.idx, io_stall_cnt, e.stall);
        end
        if (t.v && !t.x_rdy) begin
            exp_stall = exp_stall + 32'd1;
        end
    endtask

    initial begin
        vec_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

        //           v  r1 e1 r2 e2 wen wa wv wwa fl  rdy p1 p2 busy
        vecs.push_back(idle);                                           //  0 idle
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 5, 0, 0, 0, 1, 0, 0, 0)); //  1 issue x5
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); //  2 read x5 stalls
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1)); //  3 still stalls
        vecs.push_back(mk(1, 5, 1, 0, 0, 0, 0, 1, 5, 0, 1, 1, 0, 1)); //  4 x5 retires, forward
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); //  5 idle, drained
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 0, 0, 0)); //  6 issue x7
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 7, 0, 0, 0, 1, 0, 0, 1)); //  7 issue x7 again
        vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 1, 7, 0, 0, 0, 0, 1)); //  8 retire 1 of 2: no fwd
        vecs.push_back(mk(1, 0, 0, 7, 1, 0, 0, 1, 7, 0, 1, 0, 1, 1)); //  9 last retire: fwd
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 0)); // 10 x3 -> 1
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 1)); // 11 x3 -> 2
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 1)); // 12 x3 -> 3
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1)); // 13 full: stall
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 3, 0, 0, 0, 0, 1)); // 14 full + retire -> 2
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 1, 3, 0, 1, 0, 0, 1)); // 15 issue+retire: stays 2
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 1, 0, 0, 1)); // 16 x3 -> 3
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0, 0, 1)); // 17 full again
        vecs.push_back(mk(1, 3, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 1)); // 18 read x3 at 3: no fwd
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 1)); // 19 retire x3 -> 1
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 1, 0, 0, 1)); // 20 retire x3 -> 0
        vecs.push_back(idle);                                           // 21 idle
        vecs.push_back(mk(1, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0)); // 22 x0 read/write
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 0, 1, 0, 0, 0)); // 23 retire empty x9
        vecs.push_back(mk(1, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // 24 x9 still free
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0, 0)); // 25 issue x1
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 2, 0, 0, 0, 1, 0, 0, 1)); // 26 issue x2
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 4, 0, 0, 1, 0, 0, 0, 1)); // 27 flush + issue x4
        vecs.push_back(mk(1, 1, 1, 4, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0)); // 28 all cleared

        // Reset state, checked while reset is held.
        drive(idle);
        #12;
        chk("rst_ready", -1, {31'd0, io_IDU_ready}, 32'd1);
        chk("rst_pass1", -1, {31'd0, io_IDU_pass1}, 32'd0);
        chk("rst_pass2", -1, {31'd0, io_IDU_pass2}, 32'd0);
        chk("rst_busy",  -1, {31'd0, io_busy},      32'd0);
        chk("rst_stall", -1, io_stall_cnt,          32'd0);
        reset = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        // Reset asserted in the middle of a stall on x6.
        apply(mk(1, 0, 0, 0, 0, 1, 6, 0, 0, 0, 1, 0, 0, 0), 100);
        apply(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 101);
        apply(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), 102);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst_busy",  102, {31'd0, io_busy},      32'd0);
        chk("midrst_stall", 102, io_stall_cnt,          32'd0);
        chk("midrst_ready", 102, {31'd0, io_IDU_ready}, 32'd1);
        exp_stall = 32'd0;
        @(posedge clock);
        #3;
        reset = 1'b1;
        @(negedge clock);
        chk("postrst_ready", 103, {31'd0, io_IDU_ready}, 32'd1);
        chk("postrst_stall", 103, io_stall_cnt,          32'd0);
        apply(mk(1, 6, 1, 0, 0, 0, 0, 1, 6, 0, 1, 0, 0, 0), 104);   // stale retire of x6
        apply(mk(1, 6, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0), 105);   // nothing pending

        drive(idle);
        if (sb_q.size() != 0) begin
            chk("scoreboard_leftover", 999, sb_q.size(), 32'd0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule : tb_ysyx_22050550_hazard_ctrl
